// File: rtl/router_pkg.sv
// Shared defaults for the parametrised router synchroniser.
// Users can override the parameters per instance.
package router_pkg;

    localparam int ROUTER_NUM_CH  = 3;
    localparam int ROUTER_ADDR_W  = 2;
    localparam int ROUTER_TIMEOUT = 30;

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid-but-unread data, then restarts the count.
module router_sync_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Any read or loss of valid restarts the count, including in the expiry cycle.
    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (vld && !rd) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser for NUM_CH output FIFOs: latches the destination,
// steers write enables, reports full/valid and runs per-channel watchdogs.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = ROUTER_NUM_CH,
    parameter int ADDR_W  = ROUTER_ADDR_W,
    parameter int TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    // One extra bit so NUM_CH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_err_q, addr_err_d;

    always_comb begin
        addr_d     = addr_q;
        addr_err_d = addr_err_q;
        if (detect_add) begin
            addr_d     = data_in;
            addr_err_d = ({1'b0, data_in} >= NUM_CH_W);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
    assign vld_out  = ~empty;

    // A same-cycle detect_add only affects steering from the next cycle on.
    always_comb begin
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!addr_err_q && (addr_q == ADDR_W'(i))) begin
                fifo_full = full[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign write_enb[gi] = write_enb_reg && !addr_err_q && (addr_q == ADDR_W'(gi));

            router_sync_timer #(
                .TIMEOUT (TIMEOUT)
            ) u_timer (
                .clock      (clock),
                .reset      (reset),
                .vld        (vld_out[gi]),
                .rd         (read_enb[gi]),
                .soft_reset (soft_reset[gi])
            );
        end
    endgenerate

endmodule
